// File: rtl/rgb_scan_scheduler_pkg.sv
// Shared definitions for the RGB bank scan scheduler: scan FSM states,
// payload width and dwell/blank counter width.
package rgb_scan_scheduler_pkg;

   localparam int unsigned PIX_W = 256;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

endpackage

// File: rtl/rgb_bank_store.sv
// Bank payload storage: NUM_BANKS x 256-bit registers, one synchronous
// write port and one asynchronous read port, cleared by reset.
module rgb_bank_store
   import rgb_scan_scheduler_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 8,
   parameter int unsigned ADDR_W    = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data
);

   logic [PIX_W-1:0] mem [NUM_BANKS];

   // Clear all banks on reset, otherwise store the qualified write
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Combinational read of the addressed bank
   always_comb begin
      rd_data = mem[rd_addr];
   end

endmodule

// File: rtl/rgb_scan_scheduler.sv
// RGB scan scheduler: cycles through the stored banks, blanking between
// banks and presenting a latched copy of each bank while it is shown.
module rgb_scan_scheduler
   import rgb_scan_scheduler_pkg::*;
#(
   parameter int unsigned NUM_BANKS    = 8,
   parameter int unsigned DWELL_CYCLES = 5000,
   parameter int unsigned BLANK_CYCLES = 50
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 ENABLE,
   input  logic [PIX_W-1:0]     DATA_IN,
   input  logic                 DATA_WRITE,
   input  logic [7:0]           BANK_IN,
   output logic [PIX_W-1:0]     ROW_DATA,
   output logic [NUM_BANKS-1:0] ROW_SEL,
   output logic                 ROW_EN,
   output logic                 FRAME_START,
   output logic                 WRITE_ERR
);

   localparam int unsigned       BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [BANK_W-1:0] BANK_LAST  = BANK_W'(NUM_BANKS - 1);
   localparam logic [7:0]        BANK_LIMIT = 8'(NUM_BANKS);

   scan_state_t       state_q, state_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              load_row;
   logic              bank_in_range;
   logic              wr_ok;
   logic              wr_bad;
   logic [BANK_W-1:0] wr_bank;
   logic [PIX_W-1:0]  bank_rdata;
   logic [PIX_W-1:0]  row_data_q;
   logic              write_err_q;

   // Qualify incoming writes against the configured bank count
   always_comb begin
      bank_in_range = (BANK_IN < BANK_LIMIT);
      wr_ok         = DATA_WRITE && bank_in_range;
      wr_bad        = DATA_WRITE && !bank_in_range;
      wr_bank       = BANK_IN[BANK_W-1:0];
   end

   rgb_bank_store #(
      .NUM_BANKS (NUM_BANKS),
      .ADDR_W    (BANK_W)
   ) u_bank_store (
      .CLK     (CLK),
      .RESET   (RESET),
      .wr_en   (wr_ok),
      .wr_addr (wr_bank),
      .wr_data (DATA_IN),
      .rd_addr (bank_q),
      .rd_data (bank_rdata)
   );

   // State, bank index and dwell/blank counter registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         bank_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, bank advance and counter update; flags the row load
   always_comb begin
      state_d  = state_q;
      bank_d   = bank_q;
      cnt_d    = cnt_q;
      load_row = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ENABLE) begin
               state_d = ST_BLANK;
               bank_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_BLANK: begin
            if (!ENABLE) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == BLANK_LAST) begin
               state_d  = ST_SHOW;
               cnt_d    = '0;
               load_row = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHOW: begin
            if (!ENABLE) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DWELL_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               bank_d  = (bank_q == BANK_LAST) ? '0 : bank_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Drive select, enable and frame marker from the current state
   always_comb begin
      ROW_SEL     = '0;
      ROW_EN      = (state_q == ST_SHOW);
      FRAME_START = (state_q == ST_SHOW) && (bank_q == '0) && (cnt_q == '0);
      if (state_q == ST_SHOW) begin
         ROW_SEL[bank_q] = 1'b1;
      end
   end

   // Latch the bank payload only at the end of blanking; a same-cycle
   // write to that bank is forwarded since storage updates on this edge
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         row_data_q <= '0;
      end else if (load_row) begin
         row_data_q <= (wr_ok && (wr_bank == bank_q)) ? DATA_IN : bank_rdata;
      end
   end

   // One-cycle error pulse for writes aimed beyond the last bank
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         write_err_q <= 1'b0;
      end else begin
         write_err_q <= wr_bad;
      end
   end

   assign ROW_DATA  = row_data_q;
   assign WRITE_ERR = write_err_q;

endmodule

// File: doc/rgb_scan_scheduler.md
RGB_SCAN_SCHEDULER -- requirements
Module: rgb_scan_scheduler

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 8, number of stored 256-bit banks (2..8).
REQ-002 SHALL have parameter DWELL_CYCLES, default 5000, CLK cycles each bank is shown (>=1, <=65535).
REQ-003 SHALL have parameter BLANK_CYCLES, default 50, CLK cycles of blanking between banks (>=1, <=65535).
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port ENABLE  in  1  scan enable, level.
REQ-007 SHALL have port DATA_IN  in  256  bank payload from the SPI RGB receiver.
REQ-008 SHALL have port DATA_WRITE  in  1  single-cycle write strobe qualifying DATA_IN/BANK_IN.
REQ-009 SHALL have port BANK_IN  in  8  target bank index.
REQ-010 SHALL have port ROW_DATA  out  256  data of the bank being shown.
REQ-011 SHALL have port ROW_SEL  out  NUM_BANKS  one-hot bank select.
REQ-012 SHALL have port ROW_EN  out  1  output enable, high only while showing.
REQ-013 SHALL have port FRAME_START  out  1  one-cycle pulse on entering SHOW for bank 0.
REQ-014 SHALL have port WRITE_ERR  out  1  one-cycle pulse on rejected write.

Function
REQ-015 SHALL implement states IDLE, BLANK, SHOW.
REQ-016 IDLE: ROW_EN=0, ROW_SEL=0; on ENABLE=1 SHALL go to BLANK with bank index 0 and the counter cleared.
REQ-017 BLANK SHALL last exactly BLANK_CYCLES cycles with ROW_EN=0 and ROW_SEL=0.
REQ-018 On the last BLANK cycle, ROW_DATA SHALL be loaded from the current bank's storage; the next cycle SHALL enter SHOW with ROW_SEL=onehot(bank) and ROW_EN=1.
REQ-019 SHOW SHALL last exactly DWELL_CYCLES cycles, then return to BLANK with bank = bank+1, wrapping NUM_BANKS-1 -> 0.
REQ-020 FRAME_START SHALL be high in the first SHOW cycle of bank 0 only.
REQ-021 ENABLE=0 in BLANK or SHOW SHALL force IDLE the next cycle (ROW_EN=0); ROW_DATA holds its value.
REQ-022 DATA_WRITE with BANK_IN<NUM_BANKS SHALL store DATA_IN into that bank in one cycle, in any state.
REQ-023 DATA_WRITE with BANK_IN>=NUM_BANKS SHALL leave storage unchanged and pulse WRITE_ERR the next cycle.
REQ-024 A write to the bank currently shown SHALL NOT change ROW_DATA until that bank is next loaded (no tearing).
REQ-025 A write coinciding with the ROW_DATA load of the same bank SHALL forward DATA_IN into ROW_DATA.
REQ-026 Dwell/blank counters SHALL be 16 bits, count from 0, compare against parameter-1, and never wrap.

Reset
REQ-027 RESET=1 SHALL asynchronously set state IDLE, bank index 0, counter 0, all storage 0, ROW_DATA 0, ROW_SEL 0, ROW_EN 0, FRAME_START 0, WRITE_ERR 0.
REQ-028 RESET asserted mid-SHOW SHALL drop ROW_EN within the same cycle; after release scanning SHALL restart from IDLE.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE/BLANK/SHOW), the 256-bit width constant and the 16-bit counter width.
REQ-030 Bank storage SHALL be a sub-module rgb_bank_store (NUM_BANKS x 256 registers, one write port, one async read port); the FSM, counters and output registers stay in rgb_scan_scheduler.

Verification (NUM_BANKS=4, DWELL_CYCLES=8, BLANK_CYCLES=2)
REQ-031 Write bank0=all-ones, bank1=0xA5 pattern; ENABLE=1 -> ROW_EN rises 3 cycles after ENABLE; bank0 data shown 8 cycles with ROW_SEL=4'b0001 and FRAME_START once; 2 blank cycles; then bank1 with 4'b0010.
REQ-032 Run 2 full frames -> sequence 0,1,2,3,0 with FRAME_START exactly once per frame (every 40 cycles).
REQ-033 Write bank1=0x0F pattern mid-SHOW of bank1 -> ROW_DATA unchanged until bank1's next load, then 0x0F.
REQ-034 Write bank2 in the last BLANK cycle before bank2 -> ROW_DATA equals the newly written value in the first SHOW cycle.
REQ-035 BANK_IN=4 write -> WRITE_ERR one-cycle pulse, all 4 banks unchanged.
REQ-036 RESET pulse in SHOW cycle 4 -> ROW_EN, ROW_SEL, ROW_DATA 0 immediately; after release with ENABLE=1, bank0 shown after 2 blank cycles with FRAME_START.
